// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam int STATS_W = 16;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry head/tail skid buffer whose occupancy doubles as the state.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             take,
  input  logic [DSIZE-1:0] din,
  output logic [DSIZE-1:0] head,
  output logic [1:0]       count
);

  occ_t             state;
  occ_t             nextState;
  logic [DSIZE-1:0] tail;
  logic [DSIZE-1:0] nextHead;
  logic [DSIZE-1:0] nextTail;

  // Occupancy, head and tail registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= nextState;
      head  <= nextHead;
      tail  <= nextTail;
    end
  end

  // Push lands in the first free slot; a take from TWO promotes tail to head.
  always_comb begin
    nextState = state;
    nextHead  = head;
    nextTail  = tail;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            nextHead  = din;
            nextState = ONE;
          end
        end
        ONE: begin
          if (push && take) begin
            nextHead = din;
          end else if (push) begin
            nextTail  = din;
            nextState = TWO;
          end else if (take) begin
            nextState = EMPTY;
          end
        end
        TWO: begin
          if (take) begin
            nextHead  = tail;
            nextState = ONE;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  assign count = state;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a valid/ready stream via a skid buffer.
// Optional statistics counters are enabled with FIFO_RD_STATS_EN.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             flush,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       level
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STATS_W-1:0] pop_cnt,
  output logic [STATS_W-1:0] stall_cnt
`endif
);

  logic pop;
  logic take;

  // Pop depends only on registered occupancy, so m_ready never reaches rinc.
  assign pop     = !rrst && !flush && !rempty && (level != 2'(TWO));
  assign rinc    = pop;
  assign m_valid = (level != 2'(EMPTY));
  assign take    = m_valid && m_ready;

  fifo_rd_skid #(
    .DSIZE(DSIZE)
  ) u_skid (
    .clk  (rclk),
    .rst  (rrst),
    .flush(flush),
    .push (pop),
    .take (take),
    .din  (rdata),
    .head (m_data),
    .count(level)
  );

`ifdef FIFO_RD_STATS_EN
  // Free-running wrap-around counters; flush deliberately leaves them alone.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      pop_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) begin
        pop_cnt <= pop_cnt + STATS_W'(1);
      end
      if (m_valid && !m_ready) begin
        stall_cnt <= stall_cnt + STATS_W'(1);
      end
    end
  end
`endif

endmodule
